// File: rtl/xc_malu_issue_if.sv
// Requester-to-xc_malu bus: operands, one-hot op decode, variant controls,
// valid/ready/flush handshake and the two-word result.
interface xc_malu_issue_if;
  logic        valid;
  logic        flush;
  logic        ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rs3;
  logic        insn_mul;
  logic        insn_pmul;
  logic        insn_div;
  logic        insn_rem;
  logic        insn_macc;
  logic        insn_madd;
  logic        insn_msub;
  logic [4:0]  pw;
  logic        lhs_sign;
  logic        rhs_sign;
  logic        drem_unsigned;
  logic        carryless;
  logic [31:0] result_1;
  logic [31:0] result_0;

  modport master (
    output valid, flush, rs1, rs2, rs3,
    output insn_mul, insn_pmul, insn_div, insn_rem, insn_macc, insn_madd, insn_msub,
    output pw, lhs_sign, rhs_sign, drem_unsigned, carryless,
    input  ready, result_1, result_0
  );

  modport slave (
    input  valid, flush, rs1, rs2, rs3,
    input  insn_mul, insn_pmul, insn_div, insn_rem, insn_macc, insn_madd, insn_msub,
    input  pw, lhs_sign, rhs_sign, drem_unsigned, carryless,
    output ready, result_1, result_0
  );
endinterface

// File: rtl/xc_malu_issue.sv
// Initiator side of the xc_malu valid/ready/flush protocol: registers one request,
// holds it on the MALU bus until ready or timeout, then presents a response.
module xc_malu_issue #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_rs1,
  input  logic [31:0]          req_rs2,
  input  logic [31:0]          req_rs3,
  input  logic [2:0]           req_op,
  input  logic [2:0]           req_pw,
  input  logic                 req_lhs_sign,
  input  logic                 req_rhs_sign,
  input  logic                 req_drem_unsigned,
  input  logic                 req_carryless,
  input  logic                 req_hi,
  input  logic [4:0]           req_rd,
  input  logic                 pipe_kill,
  xc_malu_issue_if.master      malu,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [31:0]          rsp_data_hi,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_err,
  output logic [CNT_W-1:0]     rsp_cycles
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      rs1_q, rs2_q, rs3_q;
  logic [2:0]       op_q, pw_q;
  logic             lhs_q, rhs_q, drem_q, cl_q, hi_q;
  logic [4:0]       rd_q;
  logic             load_req;
  logic             req_illegal;
  logic             timeout;
  logic             in_issue;

  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [31:0]      rsp_hi_q, rsp_hi_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;

  // pmul with an out-of-range packed width has no legal encoding on the bus.
  assign req_illegal = (req_op == 3'd7) || ((req_op == 3'd1) && (req_pw > 3'd4));
  assign timeout     = cnt_q >= CNT_W'(TIMEOUT - 1);
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign in_issue    = (state_q == StIssue);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_req     = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    malu.valid   = 1'b0;
    malu.flush   = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;
    unique case (state_q)
      StIdle: begin
        req_ready = !pipe_kill;
        if (req_valid && !pipe_kill) begin
          load_req = 1'b1;
          cnt_d    = '0;
          if (req_illegal) begin
            state_d      = StResp;
            rsp_data_d   = '0;
            rsp_hi_d     = '0;
            rsp_err_d    = 1'b1;
            rsp_cycles_d = '0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        malu.valid = !pipe_kill;
        cnt_d      = cnt_inc;
        if (pipe_kill) begin
          malu.flush = 1'b1;
          state_d    = StIdle;
        end else if (malu.ready) begin
          malu.flush   = 1'b1;
          state_d      = StResp;
          rsp_data_d   = hi_q ? malu.result_1 : malu.result_0;
          rsp_hi_d     = malu.result_1;
          rsp_err_d    = 1'b0;
          rsp_cycles_d = cnt_inc;
        end else if (timeout) begin
          malu.flush   = 1'b1;
          state_d      = StResp;
          rsp_data_d   = '0;
          rsp_hi_d     = '0;
          rsp_err_d    = 1'b1;
          rsp_cycles_d = CNT_W'(TIMEOUT);
        end
      end
      StResp: begin
        rsp_valid = !pipe_kill;
        if (pipe_kill || rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs3_q        <= '0;
      op_q         <= '0;
      pw_q         <= '0;
      lhs_q        <= 1'b0;
      rhs_q        <= 1'b0;
      drem_q       <= 1'b0;
      cl_q         <= 1'b0;
      hi_q         <= 1'b0;
      rd_q         <= '0;
      rsp_data_q   <= '0;
      rsp_hi_q     <= '0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
      if (load_req) begin
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        rs3_q  <= req_rs3;
        op_q   <= req_op;
        pw_q   <= req_pw;
        lhs_q  <= req_lhs_sign;
        rhs_q  <= req_rhs_sign;
        drem_q <= req_drem_unsigned;
        cl_q   <= req_carryless;
        hi_q   <= req_hi;
        rd_q   <= req_rd;
      end
    end
  end

  assign malu.rs1 = rs1_q;
  assign malu.rs2 = rs2_q;
  assign malu.rs3 = rs3_q;

  // Controls are only meaningful while the MALU is being driven; keep them quiet otherwise.
  assign malu.insn_mul      = in_issue && (op_q == 3'd0);
  assign malu.insn_pmul     = in_issue && (op_q == 3'd1);
  assign malu.insn_div      = in_issue && (op_q == 3'd2);
  assign malu.insn_rem      = in_issue && (op_q == 3'd3);
  assign malu.insn_macc     = in_issue && (op_q == 3'd4);
  assign malu.insn_madd     = in_issue && (op_q == 3'd5);
  assign malu.insn_msub     = in_issue && (op_q == 3'd6);
  assign malu.pw            = !in_issue ? 5'b00000 :
                              (op_q == 3'd1) ? (5'b10000 >> pw_q) : 5'b00001;
  assign malu.lhs_sign      = in_issue && lhs_q;
  assign malu.rhs_sign      = in_issue && rhs_q;
  assign malu.drem_unsigned = in_issue && drem_q;
  assign malu.carryless     = in_issue && cl_q && ((op_q == 3'd0) || (op_q == 3'd1));

  assign rsp_data    = rsp_data_q;
  assign rsp_data_hi = rsp_hi_q;
  assign rsp_rd      = rd_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_cycles  = rsp_cycles_q;

endmodule

// File: tb/tb_xc_malu_issue.sv
// Bench for xc_malu_issue with a behavioural MALU stub of programmable latency
// and a scoreboard of expected responses.
module tb_xc_malu_issue;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 8;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic [2:0]  req_op, req_pw;
  logic        req_lhs_sign, req_rhs_sign, req_drem_unsigned, req_carryless, req_hi;
  logic [4:0]  req_rd;
  logic        pipe_kill;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data, rsp_data_hi;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [CNT_W-1:0] rsp_cycles;

  xc_malu_issue_if malu ();

  xc_malu_issue #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_rs1           (req_rs1),
    .req_rs2           (req_rs2),
    .req_rs3           (req_rs3),
    .req_op            (req_op),
    .req_pw            (req_pw),
    .req_lhs_sign      (req_lhs_sign),
    .req_rhs_sign      (req_rhs_sign),
    .req_drem_unsigned (req_drem_unsigned),
    .req_carryless     (req_carryless),
    .req_hi            (req_hi),
    .req_rd            (req_rd),
    .pipe_kill         (pipe_kill),
    .malu              (malu),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_data_hi       (rsp_data_hi),
    .rsp_rd            (rsp_rd),
    .rsp_err           (rsp_err),
    .rsp_cycles        (rsp_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- MALU stub ----------------
  logic [6:0] insn;
  logic       busy;
  int         stub_lat;
  int         stub_cnt;
  logic signed [32:0] sa, sb, quo, rem;
  logic signed [65:0] prod;

  assign insn = {malu.insn_msub, malu.insn_madd, malu.insn_macc, malu.insn_rem,
                 malu.insn_div, malu.insn_pmul, malu.insn_mul};
  assign busy = |insn;
  assign malu.ready = busy && (stub_lat != 0) && (stub_cnt == stub_lat - 1);

  always @(posedge clock) begin
    if (busy && !malu.flush) stub_cnt <= stub_cnt + 1;
    else                     stub_cnt <= 0;
  end

  always_comb begin
    sa   = {malu.lhs_sign & malu.rs1[31], malu.rs1};
    sb   = {malu.rhs_sign & malu.rs2[31], malu.rs2};
    prod = sa * sb;
    quo  = '0;
    rem  = '0;
    if (sb != 0) begin
      quo = sa / sb;
      rem = sa % sb;
    end
    malu.result_1 = 32'h0;
    malu.result_0 = 32'h0;
    if (malu.insn_mul || malu.insn_pmul) begin
      malu.result_1 = prod[63:32];
      malu.result_0 = prod[31:0];
    end else if (malu.insn_div) begin
      malu.result_0 = quo[31:0];
    end else if (malu.insn_rem) begin
      malu.result_0 = rem[31:0];
    end
  end

  // ---------------- bus monitor ----------------
  logic [4:0] exp_pw;
  logic [6:0] exp_insn;
  int valid_cnt, flush_cnt, pw_err, insn_err, cl_cnt;
  initial begin
    valid_cnt = 0; flush_cnt = 0; pw_err = 0; insn_err = 0; cl_cnt = 0;
  end
  always @(negedge clock) begin
    if (malu.valid) begin
      valid_cnt++;
      if (malu.pw !== exp_pw) pw_err++;
      if (insn !== exp_insn) insn_err++;
      if (malu.carryless) cl_cnt++;
    end
    if (malu.flush) flush_cnt++;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] dhi;
    logic [4:0]  rd;
    logic        err;
    logic [7:0]  cyc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  pw;
    logic        sgn;
    logic        cl;
    logic        hi;
    int          lat;
    int          hold;
    logic [31:0] data;
    logic [31:0] dhi;
    logic        err;
    logic [7:0]  cyc;
    logic [4:0]  pwx;
    int          vcyc;
  } tc_t;

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] pw, input logic sgn, input logic cl,
                           input logic hi, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = a ^ b;
    req_pw = pw; req_lhs_sign = sgn; req_rhs_sign = sgn; req_drem_unsigned = !sgn;
    req_carryless = cl; req_hi = hi; req_rd = rd;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input tc_t t, input logic [4:0] rd);
    int v0, f0, p0, i0, c0, n;
    exp_t e, snap;
    v0 = valid_cnt; f0 = flush_cnt; p0 = pw_err; i0 = insn_err; c0 = cl_cnt;
    exp_pw = t.pwx;
    exp_insn = 7'b1 << t.op;
    stub_lat = t.lat;
    e.data = t.data; e.dhi = t.dhi; e.rd = rd; e.err = t.err; e.cyc = t.cyc;
    sb_q.push_back(e);
    drive_req(t.op, t.rs1, t.rs2, t.pw, t.sgn, t.cl, t.hi, rd);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    check_eq("issue_cycles", 64'(n), 64'(t.vcyc));
    e = sb_q.pop_front();
    snap.data = rsp_data; snap.dhi = rsp_data_hi; snap.rd = rsp_rd;
    snap.err = rsp_err; snap.cyc = rsp_cycles;
    for (int k = 0; k < t.hold; k++) begin
      @(negedge clock);
      check_eq("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("rsp_hold_data", {rsp_data_hi, rsp_data}, {snap.dhi, snap.data});
      check_eq("rsp_hold_meta", {rsp_err, rsp_rd, rsp_cycles}, {snap.err, snap.rd, snap.cyc});
    end
    check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
    check_eq("rsp_data_hi", 64'(rsp_data_hi), 64'(e.dhi));
    check_eq("rsp_rd", 64'(rsp_rd), 64'(e.rd));
    check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
    check_eq("rsp_cycles", 64'(rsp_cycles), 64'(e.cyc));
    check_eq("req_ready_in_resp", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_ack", 64'(rsp_valid), 64'd0);
    check_eq("malu_valid_cycles", 64'(valid_cnt - v0), 64'(t.vcyc));
    check_eq("malu_flush_cycles", 64'(flush_cnt - f0), (t.vcyc > 0) ? 64'd1 : 64'd0);
    check_eq("malu_pw", 64'(pw_err - p0), 64'd0);
    check_eq("malu_insn_onehot", 64'(insn_err - i0), 64'd0);
    check_eq("malu_carryless", 64'(cl_cnt - c0),
             (t.cl && (t.op == 3'd0 || t.op == 3'd1)) ? 64'(t.vcyc) : 64'd0);
  endtask

  // Kill on the given ISSUE cycle; lat chooses whether ready coincides with it.
  task automatic kill_op(input int lat, input int kill_cycle, input string tag);
    int rv;
    stub_lat = lat;
    exp_pw = 5'b00001;
    exp_insn = 7'b0000001;
    drive_req(3'd0, 32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 1'b0, 5'd9);
    repeat (kill_cycle - 1) @(negedge clock);
    pipe_kill = 1'b1;
    #1;
    if (lat == kill_cycle) check_eq({tag, "_ready_coincident"}, 64'(malu.ready), 64'd1);
    check_eq({tag, "_flush"}, 64'(malu.flush), 64'd1);
    check_eq({tag, "_valid_low"}, 64'(malu.valid), 64'd0);
    @(negedge clock);
    pipe_kill = 1'b0;
    #1;
    check_eq({tag, "_idle_next"}, 64'(req_ready), 64'd1);
    rv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      rv = rv | int'(rsp_valid) | int'(malu.valid);
    end
    check_eq({tag, "_no_rsp"}, 64'(rv), 64'd0);
  endtask

  tc_t tcs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
    req_op = '0; req_pw = '0; req_lhs_sign = 1'b0; req_rhs_sign = 1'b0;
    req_drem_unsigned = 1'b0; req_carryless = 1'b0; req_hi = 1'b0; req_rd = '0;
    pipe_kill = 1'b0; rsp_ready = 1'b0; stub_lat = 0;
    exp_pw = 5'b00001; exp_insn = 7'b0000001;

    //        op    rs1           rs2         pw sg cl hi lat hold data          dhi   err cyc pwx       vcyc
    tcs[0]  = '{3'd0, 32'd7,        32'd6,      3'd2, 0, 0, 0, 3, 0, 32'd42,       32'd0, 0, 8'd3, 5'b00001, 3};
    tcs[1]  = '{3'd0, 32'h10000,    32'h10000,  3'd0, 0, 0, 1, 1, 0, 32'd1,        32'd1, 0, 8'd1, 5'b00001, 1};
    tcs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,      3'd0, 1, 0, 0, 5, 0, 32'hFFFFFFFD, 32'd0, 0, 8'd5, 5'b00001, 5};
    tcs[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,      3'd0, 1, 0, 0, 2, 0, 32'hFFFFFFFF, 32'd0, 0, 8'd2, 5'b00001, 2};
    tcs[4]  = '{3'd1, 32'd3,        32'd5,      3'd2, 0, 0, 0, 2, 0, 32'd15,       32'd0, 0, 8'd2, 5'b00100, 2};
    tcs[5]  = '{3'd1, 32'd2,        32'd2,      3'd0, 0, 1, 0, 1, 0, 32'd4,        32'd0, 0, 8'd1, 5'b10000, 1};
    tcs[6]  = '{3'd0, 32'd2,        32'd3,      3'd2, 0, 1, 0, 2, 0, 32'd6,        32'd0, 0, 8'd2, 5'b00001, 2};
    tcs[7]  = '{3'd2, 32'd9,        32'd3,      3'd0, 0, 1, 0, 1, 0, 32'd3,        32'd0, 0, 8'd1, 5'b00001, 1};
    tcs[8]  = '{3'd7, 32'd1,        32'd1,      3'd0, 0, 0, 0, 1, 2, 32'd0,        32'd0, 1, 8'd0, 5'b00001, 0};
    tcs[9]  = '{3'd1, 32'd1,        32'd1,      3'd5, 0, 0, 0, 1, 0, 32'd0,        32'd0, 1, 8'd0, 5'b00001, 0};
    tcs[10] = '{3'd0, 32'd9,        32'd9,      3'd0, 0, 0, 0, 0, 5, 32'd0,        32'd0, 1, 8'd8, 5'b00001, 8};
    tcs[11] = '{3'd0, 32'd5,        32'd5,      3'd0, 0, 0, 0, 8, 0, 32'd25,       32'd0, 0, 8'd8, 5'b00001, 8};
    tcs[12] = '{3'd6, 32'd1,        32'd2,      3'd4, 0, 0, 0, 2, 0, 32'd0,        32'd0, 0, 8'd2, 5'b00001, 2};

    repeat (2) @(negedge clock);
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset_malu_valid", 64'(malu.valid), 64'd0);
    check_eq("reset_malu_flush", 64'(malu.flush), 64'd0);
    check_eq("reset_rsp_fields", {rsp_data_hi, rsp_data}, 64'd0);
    check_eq("reset_rsp_meta", {rsp_err, rsp_rd, rsp_cycles}, 64'd0);
    check_eq("reset_operands", {malu.rs1, malu.rs2}, 64'd0);
    check_eq("reset_controls", {insn, malu.pw, malu.carryless}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("idle_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_op(tcs[i], 5'(i + 1));

    kill_op(0, 2, "kill_issue");
    kill_op(2, 2, "kill_vs_ready");

    // Kill in RESP drops the response; kill in IDLE blocks acceptance.
    stub_lat = 0;
    drive_req(3'd7, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd3);
    check_eq("illegal_rsp_next", 64'(rsp_valid), 64'd1);
    pipe_kill = 1'b1;
    #1;
    check_eq("kill_resp_drop", 64'(rsp_valid), 64'd0);
    check_eq("kill_idle_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    #1;
    check_eq("kill_idle_block", 64'(req_ready), 64'd0);
    pipe_kill = 1'b0;
    #1;
    check_eq("kill_release_ready", 64'(req_ready), 64'd1);

    // Reset in the middle of ISSUE returns straight to idle with no flush.
    @(negedge clock);
    drive_req(3'd0, 32'd11, 32'd12, 3'd0, 1'b0, 1'b0, 1'b0, 5'd4);
    @(negedge clock);
    check_eq("pre_reset_issue", 64'(malu.valid), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("midreset_valid", 64'(malu.valid), 64'd0);
    check_eq("midreset_flush", 64'(malu.flush), 64'd0);
    check_eq("midreset_operands", {malu.rs1, malu.rs2}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_reset_ready", 64'(req_ready), 64'd1);
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xc_malu_issue.md
Name: xc_malu_issue

Overview:
Requester-side sequencer for xc_malu, the initiator end of its valid/ready/flush protocol. It accepts one decoded multi-cycle arithmetic request from the CPU pipeline and registers the operands and controls. It drives and holds the xc_malu inputs until the MALU reports ready, then captures the result into a response register. Adds a watchdog timeout, pipeline kill and per-operation latency reporting.

Parameters:
TIMEOUT, 64, max cycles in ISSUE before abort (range 2..255).
CNT_W, 8, width of latency/watchdog counter.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  pipeline request valid
req_ready  out  1  block can accept request
req_rs1/req_rs2/req_rs3  in  32 each  operands
req_op  in  3  0 mul,1 pmul,2 div,3 rem,4 macc,5 madd,6 msub,7 illegal
req_pw  in  3  packed width select 0..4 (pmul only)
req_lhs_sign/req_rhs_sign/req_drem_unsigned/req_carryless  in  1 each  variant controls
req_hi  in  1  1: rsp_data=result_1, 0: result_0
req_rd  in  5  destination tag
pipe_kill  in  1  abandon in-flight operation
malu_valid  out  1  to xc_malu valid
malu_flush  out  1  to xc_malu flush
malu_ready  in  1  from xc_malu ready
malu_rs1/rs2/rs3  out  32 each  registered operands
malu_insn_mul..malu_insn_msub  out  1 each  one-hot decode of req_op
malu_pw  out  5  packed width one-hot
malu_lhs_sign/malu_rhs_sign/malu_drem_unsigned/malu_carryless  out  1 each
malu_result_1/malu_result_0  in  32 each  MALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  32  selected half
rsp_data_hi  out  32  result_1 always (for 64-bit writeback)
rsp_rd  out  5  tag
rsp_err  out  1  illegal op or timeout
rsp_cycles  out  CNT_W  cycles spent in ISSUE

Behaviour:
- Reset: state IDLE; all outputs 0, including operand registers, counters and rsp_*.
- States: IDLE, ISSUE, RESP.
- req_ready = (state==IDLE). Request is accepted when req_valid && req_ready. All req_* fields are registered on accept.
- IDLE, accept, op!=7: go to ISSUE next cycle. Counter cleared.
- IDLE, accept, op==7: go to RESP with rsp_err=1, rsp_data=0, rsp_data_hi=0, rsp_cycles=0. MALU is not touched.
- Decode: exactly one malu_insn_* high while in ISSUE; all are 0 outside ISSUE.
- malu_pw: if pmul, one-hot {pw==0,pw==1,pw==2,pw==3,pw==4}, MSB first; otherwise 5'b00001. pw>4 with pmul is treated as illegal.
- malu_carryless = req_carryless && (mul || pmul).
- ISSUE: malu_valid=1, and operands/controls are held stable. Counter increments every cycle.
- ISSUE, malu_ready=1: malu_flush=1 combinationally in the same cycle (flush = valid && ready). Capture result_1/result_0, rsp_cycles = counter+1, go to RESP.
- ISSUE, counter reaches TIMEOUT-1 without ready: malu_flush=1 for that cycle. Go to RESP with rsp_err=1, data 0, rsp_cycles=TIMEOUT.
- RESP: rsp_valid=1, with data stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE. There is no same-cycle re-accept, so the minimum issue-to-issue spacing is 3 cycles.
- rsp_data = req_hi ? result_1 : result_0, selected at capture.
- pipe_kill has priority over all other transitions, in any state. If in ISSUE, assert malu_flush that cycle, deassert malu_valid, and go to IDLE. If in RESP, drop rsp_valid and go to IDLE. In IDLE, kill blocks accept that cycle (req_ready=0).
- Simultaneous malu_ready and pipe_kill: kill wins and the result is discarded.
- Simultaneous malu_ready and timeout: ready wins, with rsp_err=0.
- Reset asserted mid-operation: immediate return to IDLE with outputs 0. No flush is issued; MALU shares the same reset.
- The counter saturates at 2^CNT_W-1.

Test Plan:
- mul, rs1=7, rs2=6, lhs/rhs unsigned, req_hi=0. Stub ready after 3 cycles → malu_flush for 1 cycle, rsp_data=42, rsp_data_hi=0, rsp_cycles=3, rsp_err=0.
- div, rs1=-7, rs2=2, signed, with the real xc_malu → rsp_data=0xFFFFFFFD. Then rem on the same operands → rsp_data=0xFFFFFFFF.
- pmul, pw=2 → malu_pw=5'b00100 held for the whole of ISSUE. mul with pw=2 → malu_pw=5'b00001. div with carryless=1 → malu_carryless=0.
- req_op=7 → next cycle rsp_valid=1, rsp_err=1, malu_valid never asserted.
- Stub never ready, TIMEOUT=8 → malu_flush in the 8th ISSUE cycle, rsp_err=1, rsp_cycles=8. Hold rsp_ready=0 for 5 cycles → rsp stays stable.
- pipe_kill in the 2nd ISSUE cycle → flush that cycle, IDLE next cycle, no rsp_valid. Kill coincident with malu_ready → no response.
